// File: rtl/associative_table.sv
// Fully-associative key/data table with load, count, delete and lookup commands.
// Table full -> LOAD miss replaces the round-robin victim slot.
module associative_table #(
  parameter int KEY_WIDTH  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              ctrl,
  input  logic [KEY_WIDTH-1:0]    key,
  input  logic [DATA_WIDTH-1:0]   data_input,
  output logic [DATA_WIDTH-1:0]   data_output,
  output logic                    valid,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    evict,
  output logic                    wrap
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  localparam logic [2:0] C_CLR  = 3'd1;
  localparam logic [2:0] C_LOAD = 3'd2;
  localparam logic [2:0] C_INCR = 3'd3;
  localparam logic [2:0] C_DECR = 3'd4;
  localparam logic [2:0] C_DEL  = 3'd5;
  localparam logic [2:0] C_LOOK = 3'd6;

  logic [KEY_WIDTH-1:0]  key_q  [DEPTH];
  logic [KEY_WIDTH-1:0]  key_d  [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]      vld_q, vld_d;
  logic [IDX_W-1:0]      vic_q, vic_d;

  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  valid_q, valid_d;
  logic                  evict_q, evict_d;
  logic                  wrap_q, wrap_d;

  logic                  hit;
  logic [IDX_W-1:0]      hit_idx;
  logic                  has_free;
  logic [IDX_W-1:0]      free_idx;
  logic [DATA_WIDTH-1:0] hit_data;
  logic [DATA_WIDTH-1:0] inc_data;
  logic [DATA_WIDTH-1:0] dec_data;
  logic [CNT_W-1:0]      cnt;

  // Keys are unique, so at most one entry can match.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && key_q[i] == key) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Scan downward so the lowest free index wins.
  always_comb begin
    has_free = 1'b0;
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!vld_q[i]) begin
        has_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + CNT_W'(vld_q[i]);
    end
  end

  assign hit_data = data_q[hit_idx];
  assign inc_data = hit_data + DATA_WIDTH'(1);
  assign dec_data = hit_data - DATA_WIDTH'(1);

  always_comb begin
    key_d   = key_q;
    data_d  = data_q;
    vld_d   = vld_q;
    vic_d   = vic_q;
    dout_d  = '0;
    valid_d = 1'b0;
    evict_d = 1'b0;
    wrap_d  = 1'b0;
    unique case (ctrl)
      C_CLR: begin
        vld_d = '0;
        vic_d = '0;
      end
      C_LOAD: begin
        valid_d = 1'b1;
        dout_d  = data_input;
        if (hit) begin
          data_d[hit_idx] = data_input;
        end else if (has_free) begin
          vld_d[free_idx]  = 1'b1;
          key_d[free_idx]  = key;
          data_d[free_idx] = data_input;
        end else begin
          key_d[vic_q]  = key;
          data_d[vic_q] = data_input;
          evict_d       = 1'b1;
          vic_d         = vic_q + IDX_W'(1);
        end
      end
      C_INCR: begin
        if (hit) begin
          data_d[hit_idx] = inc_data;
          valid_d         = 1'b1;
          dout_d          = inc_data;
          wrap_d          = &hit_data;
        end
      end
      C_DECR: begin
        if (hit) begin
          data_d[hit_idx] = dec_data;
          valid_d         = 1'b1;
          dout_d          = dec_data;
          wrap_d          = ~|hit_data;
        end
      end
      C_DEL: begin
        if (hit) begin
          vld_d[hit_idx] = 1'b0;
          valid_d        = 1'b1;
          dout_d         = hit_data;
        end
      end
      C_LOOK: begin
        if (hit) begin
          valid_d = 1'b1;
          dout_d  = hit_data;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        key_q[i]  <= '0;
        data_q[i] <= '0;
      end
      vld_q   <= '0;
      vic_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      evict_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        key_q[i]  <= key_d[i];
        data_q[i] <= data_d[i];
      end
      vld_q   <= vld_d;
      vic_q   <= vic_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      evict_q <= evict_d;
      wrap_q  <= wrap_d;
    end
  end

  assign data_output = dout_q;
  assign valid       = valid_q;
  assign evict       = evict_q;
  assign wrap        = wrap_q;
  assign count       = cnt;
  assign full        = (cnt == CNT_W'(DEPTH));

endmodule

// File: tb/tb_associative_table.sv
// Directed bench for associative_table with a slot-level reference model.
// A negedge compare process checks every output each cycle.
module tb_associative_table;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] ctrl;
  logic [3:0] key;
  logic [7:0] data_input;
  logic [7:0] data_output;
  logic       valid;
  logic       full;
  logic [2:0] count;
  logic       evict;
  logic       wrap;

  associative_table #(
    .KEY_WIDTH (4),
    .DATA_WIDTH(8),
    .DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ctrl       (ctrl),
    .key        (key),
    .data_input (data_input),
    .data_output(data_output),
    .valid      (valid),
    .full       (full),
    .count      (count),
    .evict      (evict),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  bit m_vld  [DEPTH];
  int m_key  [DEPTH];
  int m_data [DEPTH];
  int m_vic;

  int e_dout, e_valid, e_evict, e_wrap, e_count, e_full;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int occupied();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += m_vld[i];
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_vld[i] = 0;
    m_vic   = 0;
    e_dout  = 0;
    e_valid = 0;
    e_evict = 0;
    e_wrap  = 0;
    e_count = 0;
    e_full  = 0;
  endtask

  task automatic model(input int c, input int k, input int d);
    int h = -1;
    int f = -1;
    for (int i = 0; i < DEPTH; i++)
      if (m_vld[i] && m_key[i] == k) h = i;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!m_vld[i]) f = i;
    e_dout  = 0;
    e_valid = 0;
    e_evict = 0;
    e_wrap  = 0;
    case (c)
      1: begin
        for (int i = 0; i < DEPTH; i++) m_vld[i] = 0;
        m_vic = 0;
      end
      2: begin
        e_valid = 1;
        e_dout  = d;
        if (h >= 0) m_data[h] = d;
        else begin
          if (f < 0) begin
            f       = m_vic;
            e_evict = 1;
            m_vic   = (m_vic + 1) % DEPTH;
          end
          m_vld[f]  = 1;
          m_key[f]  = k;
          m_data[f] = d;
        end
      end
      3, 4: if (h >= 0) begin
        if (c == 3) begin
          e_wrap    = (m_data[h] == 255);
          m_data[h] = (m_data[h] + 1) % 256;
        end else begin
          e_wrap    = (m_data[h] == 0);
          m_data[h] = (m_data[h] + 255) % 256;
        end
        e_valid = 1;
        e_dout  = m_data[h];
      end
      5: if (h >= 0) begin
        e_valid  = 1;
        e_dout   = m_data[h];
        m_vld[h] = 0;
      end
      6: if (h >= 0) begin
        e_valid = 1;
        e_dout  = m_data[h];
      end
      default: ;
    endcase
    e_count = occupied();
    e_full  = (e_count == DEPTH);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("data_output", data_output, e_dout);
      chk("valid", valid, e_valid);
      chk("count", count, e_count);
      chk("full", full, e_full);
      chk("evict", evict, e_evict);
      chk("wrap", wrap, e_wrap);
    end
  end

  // Drive after the compare edge; outputs for this command are settled on return.
  task automatic cmd(input int c, input int k, input int d);
    @(negedge clk);
    #1;
    ctrl       = 3'(c);
    key        = 4'(k);
    data_input = 8'(d);
    model(c, k, d);
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst        = 1'b1;
    ctrl       = 3'd0;
    key        = 4'd0;
    data_input = 8'd0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;

    cmd(6, 1, 0);
    chk("t1_valid", valid, 0);
    chk("t1_dout", data_output, 0);
    chk("t1_count", count, 0);
    chk("t1_full", full, 0);

    cmd(2, 1, 8'hFE);
    chk("t2_load_cnt", count, 1);
    cmd(3, 1, 0);
    chk("t2_inc1", data_output, 8'hFF);
    chk("t2_wrap1", wrap, 0);
    cmd(3, 1, 0);
    chk("t2_inc2", data_output, 8'h00);
    chk("t2_wrap2", wrap, 1);
    chk("t2_valid2", valid, 1);

    cmd(1, 0, 0);
    chk("clr_count", count, 0);
    for (int i = 0; i < 4; i++) cmd(2, i, 8'h10 + i);
    chk("t3_count", count, 4);
    chk("t3_full", full, 1);
    cmd(2, 9, 8'h55);
    chk("t3_evict", evict, 1);
    cmd(6, 0, 0);
    chk("t3_k0_gone", valid, 0);
    cmd(6, 9, 0);
    chk("t3_k9", data_output, 8'h55);

    cmd(5, 2, 0);
    chk("t4_del_valid", valid, 1);
    chk("t4_del_data", data_output, 8'h12);
    chk("t4_count", count, 3);
    chk("t4_full", full, 0);
    cmd(2, 7, 8'h77);
    chk("t4_no_evict", evict, 0);
    cmd(2, 10, 8'hAA);
    chk("t4_evict_v1", evict, 1);
    cmd(6, 1, 0);
    chk("t4_k1_gone", valid, 0);
    cmd(6, 7, 0);
    chk("t4_k7_kept", data_output, 8'h77);

    cmd(2, 3, 8'h00);
    chk("t5_overwrite_noevict", evict, 0);
    cmd(4, 3, 0);
    chk("t5_dec", data_output, 8'hFF);
    chk("t5_dec_wrap", wrap, 1);
    cmd(4, 5, 0);
    chk("t5_miss_valid", valid, 0);
    cmd(5, 5, 0);
    chk("del_miss_valid", valid, 0);
    cmd(7, 3, 0);
    chk("cmd7_valid", valid, 0);

    for (int n = 0; n < 80; n++)
      cmd($urandom_range(1, 7) == 1 ? 6 : $urandom_range(2, 7),
          $urandom_range(0, 7), $urandom_range(0, 255));

    cmd(2, 4, 8'h44);
    @(negedge clk);
    #1;
    ctrl       = 3'd2;
    key        = 4'd6;
    data_input = 8'h66;
    #1;
    rst = 1'b1;
    #1;
    chk("t6_async_valid", valid, 0);
    chk("t6_async_dout", data_output, 0);
    chk("t6_async_count", count, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #1;
    rst  = 1'b0;
    ctrl = 3'd0;
    cmd(6, 6, 0);
    chk("t6_inflight_gone", valid, 0);
    cmd(2, 5, 8'h01);
    cmd(1, 0, 0);
    chk("t6_clr_count", count, 0);
    cmd(0, 0, 0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
